// File: rtl/bp_event_counter_bank.sv
// Bank of programmable event counters with shadow snapshot, sticky overflow and a
// one-cycle registered read port.
module bp_event_counter_bank #(
    parameter int unsigned num_events_p   = 32,
    parameter int unsigned num_counters_p = 8,
    parameter int unsigned width_p        = 32,
    localparam int unsigned sel_width_lp  = $clog2(num_events_p),
    localparam int unsigned idx_width_lp  = $clog2(num_counters_p)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      en_i,
    input  logic                      freeze_i,
    input  logic [num_events_p-1:0]   events_i,
    input  logic                      snapshot_i,
    input  logic                      cfg_v_i,
    input  logic [idx_width_lp-1:0]   cfg_idx_i,
    input  logic [sel_width_lp-1:0]   cfg_sel_i,
    input  logic                      cfg_mode_i,
    input  logic                      rd_v_i,
    input  logic [idx_width_lp:0]     rd_addr_i,
    output logic                      rd_v_o,
    output logic [width_p-1:0]        rd_data_o,
    output logic [num_counters_p-1:0] overflow_o
);

    logic [num_events_p-1:0]                      prev_q;
    logic [num_counters_p-1:0][width_p-1:0]       count_q, count_d;
    logic [num_counters_p-1:0][width_p-1:0]       shadow_q, shadow_d;
    logic [num_counters_p-1:0][sel_width_lp-1:0]  sel_q, sel_d;
    logic [num_counters_p-1:0]                    mode_q, mode_d;
    logic [num_counters_p-1:0]                    ovf_q, ovf_d;
    logic [num_counters_p-1:0]                    hit;
    logic                                         rd_v_q;
    logic [width_p-1:0]                           rd_data_q, rd_data_d;

    // Event select; selects beyond the last event never match and so never hit.
    always_comb begin
        hit = '0;
        for (int i = 0; i < int'(num_counters_p); i++) begin
            for (int e = 0; e < int'(num_events_p); e++) begin
                if (sel_q[i] == sel_width_lp'(e)) begin
                    hit[i] = mode_q[i] ? (events_i[e] & ~prev_q[e]) : events_i[e];
                end
            end
        end
    end

    // Per-counter update: freeze beats cfg write beats increment.
    always_comb begin
        count_d  = count_q;
        shadow_d = shadow_q;
        sel_d    = sel_q;
        mode_d   = mode_q;
        ovf_d    = ovf_q;
        for (int i = 0; i < int'(num_counters_p); i++) begin
            if (freeze_i) begin
                count_d[i]  = '0;
                shadow_d[i] = '0;
                ovf_d[i]    = 1'b0;
            end else begin
                if (snapshot_i) begin
                    shadow_d[i] = count_q[i];
                end
                if (cfg_v_i && (cfg_idx_i == idx_width_lp'(i))) begin
                    sel_d[i]   = cfg_sel_i;
                    mode_d[i]  = cfg_mode_i;
                    count_d[i] = '0;
                    ovf_d[i]   = 1'b0;
                end else if (en_i && hit[i]) begin
                    count_d[i] = count_q[i] + width_p'(1);
                    if (&count_q[i]) begin
                        ovf_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Read mux sees pre-edge state; unmapped indices return zero.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_v_i) begin
            rd_data_d = '0;
            for (int i = 0; i < int'(num_counters_p); i++) begin
                if (rd_addr_i[idx_width_lp-1:0] == idx_width_lp'(i)) begin
                    rd_data_d = rd_addr_i[idx_width_lp]
                              ? width_p'({ovf_q[i], mode_q[i], sel_q[i]})
                              : shadow_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            prev_q    <= '0;
            count_q   <= '0;
            shadow_q  <= '0;
            sel_q     <= '0;
            mode_q    <= '0;
            ovf_q     <= '0;
            rd_v_q    <= 1'b0;
            rd_data_q <= '0;
        end else begin
            prev_q    <= events_i;
            count_q   <= count_d;
            shadow_q  <= shadow_d;
            sel_q     <= sel_d;
            mode_q    <= mode_d;
            ovf_q     <= ovf_d;
            rd_v_q    <= rd_v_i;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_v_o     = rd_v_q;
    assign rd_data_o  = rd_data_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_bp_event_counter_bank.sv
// Directed and randomized bench for bp_event_counter_bank against a cycle-level
// arithmetic model of the counter bank.
module tb_bp_event_counter_bank;

    localparam int NE = 20;
    localparam int NC = 8;
    localparam int W  = 8;
    localparam int SW = 5;
    localparam int IW = 3;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          en_i, freeze_i, snapshot_i, cfg_v_i, cfg_mode_i, rd_v_i;
    logic [NE-1:0] events_i;
    logic [IW-1:0] cfg_idx_i;
    logic [SW-1:0] cfg_sel_i;
    logic [IW:0]   rd_addr_i;
    logic          rd_v_o;
    logic [W-1:0]  rd_data_o;
    logic [NC-1:0] overflow_o;

    int checks   = 0;
    int failures = 0;

    int      m_cnt[NC];
    int      m_sh[NC];
    int      m_sel[NC];
    bit      m_mode[NC];
    bit      m_ovf[NC];
    logic [NE-1:0] m_prev;
    bit      m_rdv;
    int      m_rdd;

    bp_event_counter_bank #(
        .num_events_p  (NE),
        .num_counters_p(NC),
        .width_p       (W)
    ) dut (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .en_i       (en_i),
        .freeze_i   (freeze_i),
        .events_i   (events_i),
        .snapshot_i (snapshot_i),
        .cfg_v_i    (cfg_v_i),
        .cfg_idx_i  (cfg_idx_i),
        .cfg_sel_i  (cfg_sel_i),
        .cfg_mode_i (cfg_mode_i),
        .rd_v_i     (rd_v_i),
        .rd_addr_i  (rd_addr_i),
        .rd_v_o     (rd_v_o),
        .rd_data_o  (rd_data_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            m_cnt[i] = 0; m_sh[i] = 0; m_sel[i] = 0; m_mode[i] = 0; m_ovf[i] = 0;
        end
        m_prev = '0;
        m_rdv  = 0;
        m_rdd  = 0;
    endtask

    task automatic check_outputs(input string tag);
        logic [NC-1:0] exp_ovf;
        for (int i = 0; i < NC; i++) exp_ovf[i] = m_ovf[i];
        check({tag, "_ovf"},  32'(overflow_o), 32'(exp_ovf));
        check({tag, "_rdv"},  32'(rd_v_o),     32'(m_rdv));
        check({tag, "_rdat"}, 32'(rd_data_o),  32'(m_rdd));
    endtask

    // One clock: derive next model state from current inputs, advance, compare.
    task automatic tick();
        int  n_cnt[NC];
        int  n_sh[NC];
        int  n_sel[NC];
        bit  n_mode[NC];
        bit  n_ovf[NC];
        int  rdat;
        int  idx;
        logic [NE-1:0] ev_now;
        logic [NE-1:0] cur_sh;
        logic [NE-1:0] prv_sh;
        bit  hit;
        n_cnt = m_cnt; n_sh = m_sh; n_sel = m_sel; n_mode = m_mode; n_ovf = m_ovf;
        ev_now = events_i;
        rdat = m_rdd;
        if (rd_v_i) begin
            idx  = int'(rd_addr_i) % 8;
            rdat = 0;
            if (idx < NC) begin
                if (rd_addr_i[IW])
                    rdat = (int'(m_ovf[idx]) * 64) + (int'(m_mode[idx]) * 32) + m_sel[idx];
                else
                    rdat = m_sh[idx];
            end
        end
        for (int i = 0; i < NC; i++) begin
            cur_sh = ev_now >> m_sel[i];
            prv_sh = m_prev >> m_sel[i];
            hit = (m_sel[i] < NE) && cur_sh[0] && (!m_mode[i] || !prv_sh[0]);
            if (freeze_i) begin
                n_cnt[i] = 0; n_sh[i] = 0; n_ovf[i] = 0;
            end else begin
                if (snapshot_i) n_sh[i] = m_cnt[i];
                if (cfg_v_i && int'(cfg_idx_i) == i) begin
                    n_sel[i] = int'(cfg_sel_i); n_mode[i] = cfg_mode_i;
                    n_cnt[i] = 0; n_ovf[i] = 0;
                end else if (en_i && hit) begin
                    n_cnt[i] = (m_cnt[i] + 1) % (1 << W);
                    if (n_cnt[i] == 0) n_ovf[i] = 1;
                end
            end
        end
        @(posedge clk_i);
        #1;
        m_cnt = n_cnt; m_sh = n_sh; m_sel = n_sel; m_mode = n_mode; m_ovf = n_ovf;
        m_prev = ev_now;
        m_rdv  = rd_v_i;
        m_rdd  = rdat;
        check_outputs("cyc");
    endtask

    task automatic cfg(input int idx, input int sel, input bit mode);
        cfg_v_i = 1'b1; cfg_idx_i = IW'(idx); cfg_sel_i = SW'(sel); cfg_mode_i = mode;
        tick();
        cfg_v_i = 1'b0;
    endtask

    task automatic rd(input int addr);
        rd_v_i = 1'b1; rd_addr_i = (IW+1)'(addr);
        tick();
        rd_v_i = 1'b0;
    endtask

    task automatic snap();
        snapshot_i = 1'b1;
        tick();
        snapshot_i = 1'b0;
    endtask

    initial begin
        int seq[7];
        reset_n_i = 1'b0; en_i = 1'b0; freeze_i = 1'b0; snapshot_i = 1'b0; cfg_v_i = 1'b0;
        cfg_mode_i = 1'b0; rd_v_i = 1'b0; events_i = '0; cfg_idx_i = '0; cfg_sel_i = '0;
        rd_addr_i = '0;
        model_reset();
        #12;
        check_outputs("reset");
        reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Reset contents: every shadow and config word reads zero.
        for (int a = 0; a < 16; a++) rd(a);

        // Level counting of a held event.
        en_i = 1'b1;
        cfg(0, 3, 1'b0);
        events_i[3] = 1'b1;
        repeat (10) tick();
        events_i[3] = 1'b0;
        snap();
        rd(0);
        check("t1_level10", 32'(rd_data_o), 32'd10);

        // Rising-edge counting, then one rise masked by en_i.
        seq = '{0, 1, 1, 0, 1, 0, 1};
        cfg(1, 5, 1'b1);
        for (int k = 0; k < 7; k++) begin events_i[5] = seq[k][0]; tick(); end
        events_i[5] = 1'b0;
        snap();
        rd(1);
        check("t2_edge3", 32'(rd_data_o), 32'd3);
        cfg(1, 5, 1'b1);
        for (int k = 0; k < 7; k++) begin
            events_i[5] = seq[k][0]; en_i = (k != 6); tick();
        end
        events_i[5] = 1'b0; en_i = 1'b1;
        snap();
        rd(1);
        check("t2_edge_en", 32'(rd_data_o), 32'd2);

        // Wrap sets sticky overflow; cfg write clears it.
        cfg(2, 7, 1'b0);
        events_i[7] = 1'b1;
        repeat (256) tick();
        check("t3_ovf_set", 32'(overflow_o[2]), 32'd1);
        tick();
        events_i[7] = 1'b0;
        check("t3_ovf_sticky", 32'(overflow_o[2]), 32'd1);
        snap();
        rd(2);
        check("t3_after_wrap", 32'(rd_data_o), 32'd1);
        cfg(2, 7, 1'b0);
        check("t3_ovf_clr", 32'(overflow_o[2]), 32'd0);
        snap();
        rd(2);
        check("t3_cnt_clr", 32'(rd_data_o), 32'd0);

        // Snapshot takes the pre-increment count; read sees the old shadow.
        cfg(3, 8, 1'b0);
        events_i[8] = 1'b1;
        repeat (7) tick();
        snap();
        events_i[8] = 1'b0;
        rd(3);
        check("t4_shadow7", 32'(rd_data_o), 32'd7);
        rd_v_i = 1'b1; rd_addr_i = 4'd3; snapshot_i = 1'b1;
        tick();
        rd_v_i = 1'b0; snapshot_i = 1'b0;
        check("t4_rd_snap_old", 32'(rd_data_o), 32'd7);
        rd(3);
        check("t4_shadow8", 32'(rd_data_o), 32'd8);

        // Freeze clears counts, shadows and overflow but keeps selection.
        cfg(4, 9, 1'b0);
        events_i[9] = 1'b1;
        repeat (5) tick();
        snap();
        freeze_i = 1'b1;
        tick();
        freeze_i = 1'b0;
        events_i[9] = 1'b0;
        check("t5_ovf_zero", 32'(overflow_o), 32'd0);
        for (int a = 0; a < NC; a++) begin
            rd(a);
            check("t5_shadow_zero", 32'(rd_data_o), 32'd0);
        end
        rd(8 + 4);
        check("t5_cfg_sel9", 32'(rd_data_o), 32'd9);

        // cfg write drops a same-cycle hit; an out-of-range select never counts.
        cfg(5, 10, 1'b0);
        events_i[10] = 1'b1;
        repeat (3) tick();
        cfg(5, 10, 1'b0);
        events_i[10] = 1'b0;
        snap();
        rd(5);
        check("t6_cfg_drop", 32'(rd_data_o), 32'd0);
        cfg(6, 25, 1'b0);
        events_i = '1;
        repeat (5) tick();
        events_i = '0;
        snap();
        rd(6);
        check("t6_sel_oob", 32'(rd_data_o), 32'd0);
        rd_v_i = 1'b1;
        for (int a = 0; a < NC; a++) begin
            rd_addr_i = (IW+1)'(a);
            tick();
            check("t6_b2b_rdv", 32'(rd_v_o), 32'd1);
        end
        rd_v_i = 1'b0;
        tick();
        check("t6_rdv_low", 32'(rd_v_o), 32'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 2500; c++) begin
            events_i   = NE'($urandom);
            en_i       = ($urandom % 8) != 0;
            snapshot_i = ($urandom % 10) == 0;
            cfg_v_i    = ($urandom % 40) == 0;
            cfg_idx_i  = IW'($urandom);
            cfg_sel_i  = SW'($urandom);
            cfg_mode_i = 1'($urandom);
            freeze_i   = ($urandom % 1000) == 0;
            rd_v_i     = 1'($urandom);
            rd_addr_i  = (IW+1)'($urandom);
            tick();
        end
        snapshot_i = 1'b0; cfg_v_i = 1'b0; freeze_i = 1'b0; rd_v_i = 1'b0;

        // Asynchronous reset mid-read drops rd_v_o immediately.
        rd_v_i = 1'b1; rd_addr_i = '0;
        tick();
        events_i = '0; rd_v_i = 1'b0; en_i = 1'b0;
        #2;
        reset_n_i = 1'b0;
        #1;
        model_reset();
        check("rst_mid_rdv", 32'(rd_v_o), 32'd0);
        check_outputs("rst_mid");
        #2;
        reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        for (int a = 0; a < 16; a++) rd(a);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
